regfile_reader: RTL and testbench
=================================

REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (index width 5).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request a sweep; sampled only in IDLE.
REQ-006 SHALL have ports first_reg, last_reg  input  5  inclusive sweep bounds; sampled with start.
REQ-007 SHALL have ports read_register_1, read_register_2  output  5  register-file read addresses.
REQ-008 SHALL have ports read_data_1, read_data_2  input  XLEN  register-file read data, combinational from the addresses.
REQ-009 SHALL have ports write_en (1), write_register (5), write_data (XLEN)  input  snoop of the register-file write port.
REQ-010 SHALL have ports out_valid (output 1), out_ready (input 1), out_index (output 5), out_data (output XLEN)  output stream.
REQ-011 SHALL have ports busy (output 1), done (output 1, one-cycle pulse), checksum (output XLEN).

Function
REQ-012 SHALL implement states IDLE, READ, EMIT0, EMIT1, DONE.
REQ-013 IDLE: start=1 -> latch idx=first_reg, remaining=((last_reg-first_reg) mod 32)+1 (1..32), clear checksum to 0, go READ.
REQ-014 first_reg>last_reg SHALL wrap: sweep 31 -> 0; first_reg==last_reg SHALL read exactly one register.
REQ-015 READ: drive read_register_1=idx, read_register_2=(idx+1) mod 32; capture buf0/buf1 same cycle; go EMIT0.
REQ-016 Capture SHALL forward write_data instead of read_data when write_en=1 and write_register equals the captured index.
REQ-017 While buf0/buf1 are held, a snooped write (write_en=1) to a buffered index SHALL overwrite that buffer entry with write_data.
REQ-018 EMIT0: out_valid=1, out_index=idx, out_data=buf0; out_valid, out_index, out_data SHALL stay stable until out_valid&out_ready.
REQ-019 On any handshake, checksum SHALL update to checksum XOR out_data, and remaining SHALL decrement by 1.
REQ-020 EMIT0 handshake: remaining becomes 0 -> DONE; else -> EMIT1.
REQ-021 EMIT1: out_index=(idx+1) mod 32, out_data=buf1; on handshake, idx+=2 mod 32; remaining becomes 0 -> DONE, else -> READ.
REQ-022 First out_valid SHALL assert 2 cycles after the cycle start is sampled; each register pair costs 1 READ cycle plus handshakes.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; checksum SHALL hold its final value until the next accepted start.
REQ-024 busy SHALL be 1 in every state except IDLE; start SHALL be ignored while busy.
REQ-025 read_register_1/2 SHALL hold their last values outside READ.

Reset
REQ-026 rst=1 at posedge SHALL force IDLE from any state, including mid-sweep with out_valid high, and discard buffers.
REQ-027 Reset values SHALL be: out_valid=0, busy=0, done=0, out_index=0, out_data=0, checksum=0, read_register_1/2=0.

Structure
REQ-028 XLEN, NREG, index width and the state encoding SHALL reside in shared package regfile_pkg.
REQ-029 Capture-with-forwarding SHALL be a sub-module regfile_fwd_capture (one buffer entry: index, data, snoop-update), instantiated twice.
REQ-030 No other sub-modules; no combinational path from out_ready to read_register_1/2.

Verification
REQ-031 Preload x10=15, x11=7; start first=10,last=11, out_ready=1 -> (10,15),(11,7), done 1 pulse, checksum=8.
REQ-032 first=30,last=1 -> indices 30,31,0,1 in order, remaining 4, done after 4th handshake.
REQ-033 first=last=20 (x20=15) -> single beat (20,15), no EMIT1, checksum=15.
REQ-034 Hold out_ready=0 for 5 cycles in EMIT1 while writing x11=99 -> out_data stable until snoop, then emits (11,99).
REQ-035 Write x20=42 in the READ cycle for idx=20 -> emits 42; rst asserted in EMIT1 -> next cycle out_valid=0, busy=0, checksum=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and state encoding for the register-file sweep reader
// Purpose: default data width, register count, index width and FSM state type.
// Ports: none (package).
package regfile_pkg;
  localparam int DEF_XLEN = 64;
  localparam int DEF_NREG = 32;
  localparam int IDX_W    = $clog2(DEF_NREG);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EMIT0,
    EMIT1,
    DONE
  } state_t;
endpackage

// File: rtl/regfile_fwd_capture.sv
// rtl/regfile_fwd_capture.sv - one buffered register entry with write forwarding and snoop update
// Purpose: holds one (index, data) pair read from the register file and keeps it coherent
//          with writes that land while it is held.
// Ports: clk, rst (sync, active-high); capture/cap_index/rd_data load a new entry;
//        write_en/write_register/write_data snoop the register-file write port;
//        index/data present the held entry.
module regfile_fwd_capture
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [IDX_W-1:0] cap_index,
  input  logic [XLEN-1:0]  rd_data,
  input  logic             write_en,
  input  logic [IDX_W-1:0] write_register,
  input  logic [XLEN-1:0]  write_data,
  output logic [IDX_W-1:0] index,
  output logic [XLEN-1:0]  data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      index <= '0;
      data  <= '0;
    end else if (capture) begin
      index <= cap_index;
      // A write landing in the capture cycle is not yet visible on rd_data.
      data  <= (write_en && (write_register == cap_index)) ? write_data : rd_data;
    end else if (write_en && (write_register == index)) begin
      data <= write_data;
    end
  end

endmodule

// File: rtl/regfile_reader.sv
// rtl/regfile_reader.sv - sweeps a register range in pairs and streams (index, data) beats
// Purpose: on start, reads registers first_reg..last_reg (wrapping), emits each on the
//          out_* stream with backpressure, and accumulates an XOR checksum.
// Ports: clk, rst (sync, active-high); start/first_reg/last_reg request a sweep;
//        read_register_1/2 and read_data_1/2 drive the register-file read ports;
//        write_en/write_register/write_data snoop the write port;
//        out_valid/out_ready/out_index/out_data form the output stream;
//        busy, done (one-cycle pulse) and checksum report status.
module regfile_reader
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] first_reg,
  input  logic [IDX_W-1:0] last_reg,
  output logic [IDX_W-1:0] read_register_1,
  output logic [IDX_W-1:0] read_register_2,
  input  logic [XLEN-1:0]  read_data_1,
  input  logic [XLEN-1:0]  read_data_2,
  input  logic             write_en,
  input  logic [IDX_W-1:0] write_register,
  input  logic [XLEN-1:0]  write_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [XLEN-1:0]  out_data,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  checksum
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);
  localparam logic [IDX_W:0]   REM_ONE  = (IDX_W + 1)'(1);

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   remaining;
  logic [IDX_W-1:0] buf0_index, buf1_index;
  logic [XLEN-1:0]  buf0_data, buf1_data;
  logic             capture;

  assign capture = (state == READ);

  regfile_fwd_capture #(.XLEN(XLEN)) u_buf0 (
    .clk           (clk),
    .rst           (rst),
    .capture       (capture),
    .cap_index     (read_register_1),
    .rd_data       (read_data_1),
    .write_en      (write_en),
    .write_register(write_register),
    .write_data    (write_data),
    .index         (buf0_index),
    .data          (buf0_data)
  );

  regfile_fwd_capture #(.XLEN(XLEN)) u_buf1 (
    .clk           (clk),
    .rst           (rst),
    .capture       (capture),
    .cap_index     (read_register_2),
    .rd_data       (read_data_2),
    .write_en      (write_en),
    .write_register(write_register),
    .write_data    (write_data),
    .index         (buf1_index),
    .data          (buf1_data)
  );

  // Read addresses are loaded on entry to READ so they are pure registers,
  // holding their last value everywhere else and never depending on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      remaining       <= '0;
      checksum        <= '0;
      read_register_1 <= '0;
      read_register_2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx             <= first_reg;
            remaining       <= {1'b0, IDX_W'(last_reg - first_reg)} + REM_ONE;
            checksum        <= '0;
            read_register_1 <= first_reg;
            read_register_2 <= inc_idx(first_reg);
            state           <= READ;
          end
        end
        READ: state <= EMIT0;
        EMIT0: begin
          if (out_ready) begin
            checksum  <= checksum ^ buf0_data;
            remaining <= remaining - REM_ONE;
            state     <= (remaining == REM_ONE) ? DONE : EMIT1;
          end
        end
        EMIT1: begin
          if (out_ready) begin
            checksum  <= checksum ^ buf1_data;
            remaining <= remaining - REM_ONE;
            idx       <= inc_idx(inc_idx(idx));
            if (remaining == REM_ONE) begin
              state <= DONE;
            end else begin
              read_register_1 <= inc_idx(inc_idx(idx));
              read_register_2 <= inc_idx(inc_idx(inc_idx(idx)));
              state           <= READ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == EMIT0) || (state == EMIT1);
  assign out_index = (state == EMIT1) ? buf1_index : buf0_index;
  assign out_data  = (state == EMIT1) ? buf1_data : buf0_data;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_regfile_reader.sv
// tb/tb_regfile_reader.sv - scoreboard bench for regfile_reader
module tb_regfile_reader;
  logic        clk = 1'b0;
  logic        rst, start, write_en, out_ready;
  logic [4:0]  first_reg, last_reg, write_register;
  logic [4:0]  read_register_1, read_register_2, out_index;
  logic [63:0] read_data_1, read_data_2, write_data, out_data, checksum;
  logic        out_valid, busy, done;

  logic [63:0] rf [32];

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
  } beat_t;
  beat_t sb[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  assign read_data_1 = rf[read_register_1];
  assign read_data_2 = rf[read_register_2];

  regfile_reader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .first_reg      (first_reg),
    .last_reg       (last_reg),
    .read_register_1(read_register_1),
    .read_register_2(read_register_2),
    .read_data_1    (read_data_1),
    .read_data_2    (read_data_2),
    .write_en       (write_en),
    .write_register (write_register),
    .write_data     (write_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_index      (out_index),
    .out_data       (out_data),
    .busy           (busy),
    .done           (done),
    .checksum       (checksum)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] i, input logic [63:0] d);
    beat_t b;
    b.idx  = i;
    b.data = d;
    sb.push_back(b);
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (done_cnt != d0) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  // Monitor: compares every accepted beat against the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (done) done_cnt++;
    if (out_valid && out_ready && !rst) begin
      hs_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected actual=%0d/%0h required=none", out_index, out_data);
      end else begin
        e = sb.pop_front();
        if (out_index !== e.idx || out_data !== e.data) begin
          errors++;
          $display("FAIL beat actual=%0d/%0h required=%0d/%0h", out_index, out_data, e.idx, e.data);
        end
      end
    end
  end

  initial begin
    int d0, h0;
    for (int i = 0; i < 32; i++) rf[i] = 64'h0;
    rst = 1'b1; start = 1'b0; write_en = 1'b0; out_ready = 1'b1;
    first_reg = '0; last_reg = '0; write_register = '0; write_data = '0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_out_index", {59'b0, out_index}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_checksum", checksum, 64'd0);
    check("rst_rr1", {59'b0, read_register_1}, 64'd0);
    check("rst_rr2", {59'b0, read_register_2}, 64'd0);

    // Basic pair sweep x10..x11
    rf[10] = 64'd15; rf[11] = 64'd7;
    push(5'd10, 64'd15); push(5'd11, 64'd7);
    d0 = done_cnt;
    first_reg = 5'd10; last_reg = 5'd11; start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_valid_c1", {63'b0, out_valid}, 64'd0);
    check("busy_c1", {63'b0, busy}, 64'd1);
    check("rr1_read", {59'b0, read_register_1}, 64'd10);
    check("rr2_read", {59'b0, read_register_2}, 64'd11);
    tick();
    check("lat_valid_c2", {63'b0, out_valid}, 64'd1);
    wait_done("pair", 20);
    tick();
    check("pair_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("pair_checksum", checksum, 64'd8);
    check("pair_busy_after", {63'b0, busy}, 64'd0);
    check("pair_rr1_hold", {59'b0, read_register_1}, 64'd10);

    // Wrapping sweep 30 -> 1
    rf[30] = 64'h1; rf[31] = 64'h2; rf[0] = 64'h4; rf[1] = 64'h8;
    push(5'd30, 64'h1); push(5'd31, 64'h2); push(5'd0, 64'h4); push(5'd1, 64'h8);
    h0 = hs_cnt;
    first_reg = 5'd30; last_reg = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("wrap", 40);
    check("wrap_beats", 64'(hs_cnt - h0), 64'd4);
    check("wrap_checksum", checksum, 64'hF);

    // Single register
    rf[20] = 64'd15; rf[21] = 64'h55;
    push(5'd20, 64'd15);
    h0 = hs_cnt;
    first_reg = 5'd20; last_reg = 5'd20; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("single", 20);
    check("single_beats", 64'(hs_cnt - h0), 64'd1);
    check("single_checksum", checksum, 64'd15);

    // Backpressure in EMIT1 with a snooped write to the held index
    push(5'd10, 64'd15); push(5'd11, 64'd99);
    out_ready = 1'b0;
    first_reg = 5'd10; last_reg = 5'd11; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("bp_e0_index", {59'b0, out_index}, 64'd10);
    check("bp_e0_data", out_data, 64'd15);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_e1_index", {59'b0, out_index}, 64'd11);
    check("bp_e1_data", out_data, 64'd7);
    repeat (2) tick();
    check("bp_stable_valid", {63'b0, out_valid}, 64'd1);
    check("bp_stable_data", out_data, 64'd7);
    write_en = 1'b1; write_register = 5'd11; write_data = 64'd99;
    tick();
    write_en = 1'b0;
    rf[11] = 64'd99;
    check("bp_snoop_data", out_data, 64'd99);
    check("bp_snoop_index", {59'b0, out_index}, 64'd11);
    tick();
    out_ready = 1'b1;
    wait_done("bp", 20);
    check("bp_checksum", checksum, 64'd108);

    // Forward in READ, then reset mid-sweep in EMIT1
    push(5'd20, 64'd42);
    out_ready = 1'b0;
    first_reg = 5'd20; last_reg = 5'd21; start = 1'b1;
    tick();
    start = 1'b0;
    write_en = 1'b1; write_register = 5'd20; write_data = 64'd42;
    tick();
    write_en = 1'b0;
    rf[20] = 64'd42;
    check("fwd_data", out_data, 64'd42);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fwd_e1_index", {59'b0, out_index}, 64'd21);
    check("fwd_checksum", checksum, 64'd42);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {63'b0, out_valid}, 64'd0);
    check("mid_rst_busy", {63'b0, busy}, 64'd0);
    check("mid_rst_checksum", checksum, 64'd0);
    check("mid_rst_data", out_data, 64'd0);
    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
